// File: rtl/accum_drain_stage_if.sv
// accum_drain_stage_if
//   Bundles the per-beat upstream signals, the result handshake and the
//   status outputs of accum_drain_stage.
//   slave  : the accumulate/drain stage itself.
//   master : whoever drives the beats and consumes results (upstream pipe,
//            downstream sink, or a bench).
//   Signals:
//     in_valid, in_data, co_filter_in, done_in : beat from upstream
//     stall_out                                : upstream must hold
//     out_valid, out_ready, out_data           : result handshake
//     beat_cnt, done_out, busy, state_dbg      : status / debug
//   Handshake: a beat is consumed on a rising edge where in_valid=1 and
//   stall_out=0. A result transfers on a rising edge where out_valid=1 and
//   out_ready=1. out_data stays stable while out_valid=1 and the result has
//   not transferred.
interface accum_drain_stage_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 6
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         co_filter_in;
  logic                         done_in;
  logic                         stall_out;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic [CNT_WIDTH-1:0]         beat_cnt;
  logic                         done_out;
  logic                         busy;
  logic [1:0]                   state_dbg;

  modport slave (
    input  in_valid, in_data, co_filter_in, done_in, out_ready,
    output stall_out, out_valid, out_data, beat_cnt, done_out, busy, state_dbg
  );

  modport master (
    output in_valid, in_data, co_filter_in, done_in, out_ready,
    input  stall_out, out_valid, out_data, beat_cnt, done_out, busy, state_dbg
  );
endinterface

// File: rtl/accum_drain_stage.sv
// accum_drain_stage
//   Accumulates the signed per-tap products of one filter window and emits
//   one saturated result per window over a valid/ready handshake. While a
//   result is waiting, upstream is stalled. A done beat flushes the last
//   result, then pulses done_out for one cycle.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : accum_drain_stage_if.slave (beats in, result out, status)
//   state_dbg encodes the FSM: 0=IDLE 1=ACCUM 2=FLUSH 3=DONE.
//   ACC_WIDTH must be greater than DATA_WIDTH.
module accum_drain_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  accum_drain_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The most negative value is the bitwise complement of the most positive one.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[OUT_WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    else                  return x[OUT_WIDTH-1:0];
  endfunction

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic                         ov_q, ov_d;
  logic signed [OUT_WIDTH-1:0]  od_q, od_d;

  logic                         stall;
  logic                         accept;
  logic                         close_win;
  logic signed [ACC_WIDTH-1:0]  sum;

  // Stall whenever a result is waiting, even for a beat that would not
  // close a window; FLUSH never takes beats.
  assign stall  = (ov_q & ~bus.out_ready) | (state_q == S_FLUSH);
  assign accept = bus.in_valid & ~stall;
  assign sum    = acc_q + {{(ACC_WIDTH-DATA_WIDTH){bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
  // A done beat in ACCUM closes the window even without co_filter so the
  // partial sum is not lost.
  assign close_win = bus.co_filter_in | ((state_q == S_ACCUM) & bus.done_in);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    od_d    = od_q;

    if (ov_q & bus.out_ready) ov_d = 1'b0;

    // A closing beat may land on the same edge as a drain (out_ready=1);
    // the new result then replaces the one just taken.
    if (accept) begin
      if (close_win) begin
        od_d  = sat(sum);
        ov_d  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE:  if (accept) state_d = S_ACCUM;
      S_ACCUM: if (accept & bus.done_in) state_d = S_FLUSH;
      S_FLUSH: if (~ov_q | bus.out_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  assign bus.stall_out = stall;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.beat_cnt  = cnt_q;
  assign bus.done_out  = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.state_dbg = state_q;

endmodule
